// File: rtl/fslam_pkg.sv
// Shared types and default widths for the FAST keypoint collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fslam_pkg;

   // Default pipeline geometry and the widths derived from it
   localparam int PIXEL_SCORE_DEPTH_DEF = 13;
   localparam int IMG_WIDTH_DEF         = 640;
   localparam int IMG_HEIGHT_DEF        = 480;
   localparam int FIFO_DEPTH_DEF        = 16;
   localparam int MAX_KP_DEF            = 1024;
   localparam int X_W_DEF               = $clog2(IMG_WIDTH_DEF);
   localparam int Y_W_DEF               = $clog2(IMG_HEIGHT_DEF);
   localparam int CNT_W_DEF             = $clog2(MAX_KP_DEF + 1);

   // Keypoint record at the default geometry; score sits in the top bits.
   // The collector declares the same layout at its own parameterised widths.
   typedef struct packed {
      logic [PIXEL_SCORE_DEPTH_DEF-1:0] score;
      logic [Y_W_DEF-1:0]               y;
      logic [X_W_DEF-1:0]               x;
   } kp_entry_t;

   // Collector frame state
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      CAPPED = 2'd2
   } kp_state_e;

endpackage

// File: rtl/kp_fifo.sv
// Small synchronous first-word-fall-through FIFO for keypoint records.
// Latency: a push at edge t is visible on head/empty right after t.
// Backpressure: full is registered; pushes while full and pops while empty are ignored.
module kp_fifo #(
   parameter int  DEPTH   = 16,
   parameter type ENTRY_T = logic [31:0]
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  ENTRY_T push_data,
   output logic   full,
   input  logic   pop,
   output ENTRY_T head,
   output logic   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   ENTRY_T             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               do_push;
   logic               do_pop;

   assign full  = (occ_q == OCC_W'(DEPTH));
   assign empty = (occ_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      occ_d    = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage array; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/keypoint_collector.sv
// Tags non-zero NMS scores with (x,y), buffers them, caps per frame and reports frame stats.
// Latency: keypoint visible on kp_* the cycle after its beat; frame_done one cycle after the closing beat.
// Backpressure: none upstream; FIFO-full or cap losses are flagged via frame_dropped.
module keypoint_collector
   import fslam_pkg::*;
#(
   parameter  int PIXEL_SCORE_DEPTH = 13,
   parameter  int IMG_WIDTH         = 640,
   parameter  int IMG_HEIGHT        = 480,
   parameter  int FIFO_DEPTH        = 16,
   parameter  int MAX_KP            = 1024,
   localparam int X_W               = $clog2(IMG_WIDTH),
   localparam int Y_W               = $clog2(IMG_HEIGHT),
   localparam int CNT_W             = $clog2(MAX_KP + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic                         in_sof,
   input  logic [PIXEL_SCORE_DEPTH-1:0] in_score,
   output logic                         kp_valid,
   input  logic                         kp_ready,
   output logic [X_W-1:0]               kp_x,
   output logic [Y_W-1:0]               kp_y,
   output logic [PIXEL_SCORE_DEPTH-1:0] kp_score,
   output logic                         frame_done,
   output logic [CNT_W-1:0]             frame_kp_count,
   output logic                         frame_dropped,
   output logic                         frame_short
);

   typedef struct packed {
      logic [PIXEL_SCORE_DEPTH-1:0] score;
      logic [Y_W-1:0]               y;
      logic [X_W-1:0]               x;
   } entry_t;

   localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_WIDTH - 1);
   localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_KP);

   kp_state_e          state_q, state_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [CNT_W-1:0]   kp_cnt_q, kp_cnt_d;
   logic               drop_q, drop_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   stat_cnt_q, stat_cnt_d;
   logic               stat_drop_q, stat_drop_d;
   logic               stat_short_q, stat_short_d;

   kp_state_e          beat_state;
   logic               beat_en;
   logic [X_W-1:0]     bx;
   logic [Y_W-1:0]     by;
   logic               push;
   entry_t             push_data;
   entry_t             head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;

   assign kp_valid       = ~fifo_empty;
   assign pop            = kp_valid & kp_ready;
   assign kp_x           = kp_valid ? head.x     : '0;
   assign kp_y           = kp_valid ? head.y     : '0;
   assign kp_score       = kp_valid ? head.score : '0;
   assign frame_done     = done_q;
   assign frame_kp_count = stat_cnt_q;
   assign frame_dropped  = stat_drop_q;
   assign frame_short    = stat_short_q;

   // Frame FSM: sof handling first, then the keypoint decision on the resulting state, then raster advance
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      kp_cnt_d     = kp_cnt_q;
      drop_d       = drop_q;
      done_d       = 1'b0;
      stat_cnt_d   = stat_cnt_q;
      stat_drop_d  = stat_drop_q;
      stat_short_d = stat_short_q;
      beat_en      = 1'b0;
      beat_state   = state_q;
      bx           = x_q;
      by           = y_q;
      push         = 1'b0;

      if (in_valid) begin
         if (in_sof) begin
            // An sof inside a frame closes it as short; the same beat opens the next frame
            if (state_q != IDLE) begin
               done_d       = 1'b1;
               stat_cnt_d   = kp_cnt_q;
               stat_drop_d  = drop_q;
               stat_short_d = 1'b1;
            end
            beat_en    = 1'b1;
            beat_state = ACTIVE;
            bx         = '0;
            by         = '0;
            kp_cnt_d   = '0;
            drop_d     = 1'b0;
         end else if (state_q != IDLE) begin
            beat_en = 1'b1;
         end
      end

      if (beat_en) begin
         state_d = beat_state;
         if (in_score != '0) begin
            if (beat_state == ACTIVE && !fifo_full) begin
               push     = 1'b1;
               kp_cnt_d = kp_cnt_d + CNT_W'(1);
            end else begin
               drop_d = 1'b1;
            end
         end
         if (beat_state == ACTIVE && kp_cnt_d == CNT_CAP) begin
            state_d = CAPPED;
         end
         if (bx == X_LAST) begin
            x_d = '0;
            if (by == Y_LAST) begin
               y_d          = '0;
               state_d      = IDLE;
               done_d       = 1'b1;
               stat_cnt_d   = kp_cnt_d;
               stat_drop_d  = drop_d;
               stat_short_d = 1'b0;
            end else begin
               y_d = by + Y_W'(1);
            end
         end else begin
            x_d = bx + X_W'(1);
            y_d = by;
         end
      end
   end

   assign push_data = '{score: in_score, y: by, x: bx};

   // State, raster position, per-frame counters and held stats
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         kp_cnt_q     <= '0;
         drop_q       <= 1'b0;
         done_q       <= 1'b0;
         stat_cnt_q   <= '0;
         stat_drop_q  <= 1'b0;
         stat_short_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         kp_cnt_q     <= kp_cnt_d;
         drop_q       <= drop_d;
         done_q       <= done_d;
         stat_cnt_q   <= stat_cnt_d;
         stat_drop_q  <= stat_drop_d;
         stat_short_q <= stat_short_d;
      end
   end

   kp_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .ENTRY_T (entry_t)
   ) u_kp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .full      (fifo_full),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_keypoint_collector.sv
// Bench for keypoint_collector in the small 8x4 test geometry.
// Latency: compares outputs every cycle against a frame/queue reference model.
// Backpressure: kp_ready is driven by the stimulus (held low, random, or always high).
module tb_keypoint_collector;

   localparam int SD = 13;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int D  = 4;
   localparam int MK = 6;
   localparam int XW = 3;
   localparam int YW = 2;
   localparam int CW = 3;
   localparam int EW = SD + YW + XW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_sof;
   logic [SD-1:0] in_score;
   logic          kp_valid;
   logic          kp_ready;
   logic [XW-1:0] kp_x;
   logic [YW-1:0] kp_y;
   logic [SD-1:0] kp_score;
   logic          frame_done;
   logic [CW-1:0] frame_kp_count;
   logic          frame_dropped;
   logic          frame_short;

   keypoint_collector #(
      .PIXEL_SCORE_DEPTH (SD),
      .IMG_WIDTH         (W),
      .IMG_HEIGHT        (H),
      .FIFO_DEPTH        (D),
      .MAX_KP            (MK)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_sof         (in_sof),
      .in_score       (in_score),
      .kp_valid       (kp_valid),
      .kp_ready       (kp_ready),
      .kp_x           (kp_x),
      .kp_y           (kp_y),
      .kp_score       (kp_score),
      .frame_done     (frame_done),
      .frame_kp_count (frame_kp_count),
      .frame_dropped  (frame_dropped),
      .frame_short    (frame_short)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: frame progress as a pixel index, FIFO as a queue
   logic [EW-1:0] m_q[$];
   bit            m_inframe;
   int            m_pix;
   int            m_cnt;
   bit            m_drop;
   bit            m_done;
   int            m_fcnt;
   bit            m_fdrop;
   bit            m_fshort;

   logic [EW-1:0] dut_pops[$];
   int            n_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_inframe = 0;
      m_pix     = 0;
      m_cnt     = 0;
      m_drop    = 0;
      m_done    = 0;
      m_fcnt    = 0;
      m_fdrop   = 0;
      m_fshort  = 0;
   endtask

   task automatic model_close(input bit short_f);
      m_done   = 1;
      m_fcnt   = m_cnt;
      m_fdrop  = m_drop;
      m_fshort = short_f;
   endtask

   task automatic model_edge(input logic v, input logic s, input logic [SD-1:0] sc, input logic rdy);
      int            sz0;
      bit            do_push;
      logic [EW-1:0] e;
      sz0     = m_q.size();
      do_push = 0;
      e       = '0;
      m_done  = 0;
      if (v) begin
         if (s) begin
            if (m_inframe) model_close(1);
            m_inframe = 1;
            m_pix     = 0;
            m_cnt     = 0;
            m_drop    = 0;
         end
         if (m_inframe) begin
            if (sc != 0) begin
               if (m_cnt >= MK || sz0 == D) begin
                  m_drop = 1;
               end else begin
                  do_push = 1;
                  e       = {sc, YW'(m_pix / W), XW'(m_pix % W)};
                  m_cnt++;
               end
            end
            m_pix++;
            if (m_pix == W * H) begin
               model_close(0);
               m_inframe = 0;
            end
         end
      end
      if (rdy && sz0 > 0) void'(m_q.pop_front());
      if (do_push) m_q.push_back(e);
   endtask

   // One clock: drive, compare pre-edge outputs with the model, advance both
   task automatic cycle(input logic v, input logic s, input logic [SD-1:0] sc, input logic rdy);
      logic [EW-1:0] hd;
      in_valid = v;
      in_sof   = s;
      in_score = sc;
      kp_ready = rdy;
      check_eq("kp_valid", kp_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         hd = m_q[0];
         check_eq("kp_x", kp_x, hd[XW-1:0]);
         check_eq("kp_y", kp_y, hd[XW+YW-1:XW]);
         check_eq("kp_score", kp_score, hd[EW-1:XW+YW]);
      end
      check_eq("frame_done", frame_done, m_done);
      check_eq("frame_kp_count", frame_kp_count, m_fcnt);
      check_eq("frame_dropped", frame_dropped, m_fdrop);
      check_eq("frame_short", frame_short, m_fshort);
      if (kp_valid && rdy) dut_pops.push_back({kp_score, kp_y, kp_x});
      if (frame_done) n_done++;
      model_edge(v, s, sc, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_score = '0;
      kp_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic clear_obs();
      dut_pops.delete();
      n_done = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            rth;
      logic          v;
      logic          s;
      logic          r;
      logic [SD-1:0] sc;
      logic [EW-1:0] exp_e;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_score = '0;
      kp_ready = 1'b0;
      @(posedge clk);
      apply_reset();
      check_eq("rst_kp_valid", kp_valid, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_count", frame_kp_count, 0);
      check_eq("rst_dropped", frame_dropped, 0);
      check_eq("rst_short", frame_short, 0);

      // Basic frame
      clear_obs();
      for (int p = 0; p < W * H; p++)
         cycle(1'b1, p == 0, (p == 3) ? SD'(5) : (p == 17) ? SD'(9) : SD'(0), 1'b1);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
      check_eq("basic_pops", dut_pops.size(), 2);
      if (dut_pops.size() >= 2) begin
         check_eq("basic_kp0", dut_pops[0], {13'd5, 2'd0, 3'd3});
         check_eq("basic_kp1", dut_pops[1], {13'd9, 2'd2, 3'd1});
      end
      check_eq("basic_count", frame_kp_count, 2);
      check_eq("basic_dropped", frame_dropped, 0);
      check_eq("basic_short", frame_short, 0);
      check_eq("basic_done_pulses", n_done, 1);

      // FIFO full with the consumer stalled
      clear_obs();
      for (int p = 0; p < W * H; p++)
         cycle(1'b1, p == 0, (p >= 2 && p < 8) ? SD'(p + 1) : SD'(0), 1'b0);
      repeat (2) cycle(1'b0, 1'b0, '0, 1'b0);
      check_eq("full_count", frame_kp_count, 4);
      check_eq("full_dropped", frame_dropped, 1);
      repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);
      check_eq("full_pops", dut_pops.size(), 4);
      for (int i = 0; i < 4 && i < dut_pops.size(); i++) begin
         exp_e = {SD'(i + 3), 2'd0, XW'(i + 2)};
         check_eq("full_order", dut_pops[i], exp_e);
      end

      // Per-frame cap, then the following frame accepts again
      clear_obs();
      for (int p = 0; p < W * H; p++)
         cycle(1'b1, p == 0, (p >= 1 && p <= 10) ? SD'($urandom_range(1, (1 << SD) - 1)) : SD'(0), 1'b1);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
      check_eq("cap_pops", dut_pops.size(), 6);
      check_eq("cap_count", frame_kp_count, 6);
      check_eq("cap_dropped", frame_dropped, 1);
      clear_obs();
      for (int p = 0; p < W * H; p++)
         cycle(1'b1, p == 0, (p == 5) ? SD'(42) : SD'(0), 1'b1);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
      check_eq("postcap_pops", dut_pops.size(), 1);
      check_eq("postcap_count", frame_kp_count, 1);
      check_eq("postcap_dropped", frame_dropped, 0);

      // Early sof at beat 12 carrying a keypoint
      clear_obs();
      for (int p = 0; p < 12; p++)
         cycle(1'b1, p == 0, (p == 2 || p == 7) ? SD'(p + 20) : SD'(0), 1'b1);
      cycle(1'b1, 1'b1, SD'(77), 1'b1);
      check_eq("esof_done", frame_done, 1);
      check_eq("esof_short", frame_short, 1);
      check_eq("esof_count", frame_kp_count, 2);
      for (int p = 1; p < W * H; p++) cycle(1'b1, 1'b0, '0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
      check_eq("esof_pops", dut_pops.size(), 3);
      if (dut_pops.size() >= 3) check_eq("esof_kp_origin", dut_pops[2], {13'd77, 2'd0, 3'd0});
      check_eq("esof_next_short", frame_short, 0);
      check_eq("esof_next_count", frame_kp_count, 1);

      // Reset mid-frame with three buffered keypoints
      clear_obs();
      for (int p = 0; p < 10; p++)
         cycle(1'b1, p == 0, (p >= 1 && p <= 3) ? SD'(p) : SD'(0), 1'b0);
      check_eq("midrst_pre_valid", kp_valid, 1);
      apply_reset();
      check_eq("midrst_kp_valid", kp_valid, 0);
      check_eq("midrst_done", frame_done, 0);
      for (int p = 0; p < 10; p++) cycle(1'b1, 1'b0, SD'(p + 1), 1'b1);
      check_eq("midrst_ignored_pops", dut_pops.size(), 0);
      check_eq("midrst_no_done", n_done, 0);

      // sof without in_valid does not open a frame
      clear_obs();
      cycle(1'b0, 1'b1, SD'(55), 1'b1);
      for (int p = 0; p < 10; p++) cycle(1'b1, 1'b0, SD'(p + 3), 1'b1);
      check_eq("sofq_pops", dut_pops.size(), 0);
      check_eq("sofq_no_done", n_done, 0);

      // Randomised traffic with varying consumer throttle
      for (int c = 0; c < 3000; c++) begin
         rth = (c / 500) % 3;
         v   = ($urandom % 4) != 0;
         if (m_inframe) s = v && (($urandom % 150) == 0);
         else           s = ($urandom % 6) == 0;
         sc  = (($urandom % 4) == 0) ? SD'($urandom_range(1, (1 << SD) - 1)) : SD'(0);
         r   = (rth == 0) ? 1'b1 : (rth == 1) ? 1'($urandom % 2) : 1'(($urandom % 6) == 0);
         cycle(v, s, sc, r);
         if (c == 1700) apply_reset();
      end
      repeat (10) cycle(1'b0, 1'b0, '0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/keypoint_collector.md
Name: keypoint_collector

Overview:
- Sits directly downstream of the NMS stage in the FAST feature pipeline.
- Consumes the raster-ordered, suppressed score stream, in which a zero score means "not a keypoint".
- Tags each surviving non-zero score with its (x, y) pixel coordinate and buffers it in a small FIFO with a valid/ready output handshake.
- Enforces a per-frame keypoint cap and reports per-frame statistics on frame completion.

Parameters:
- PIXEL_SCORE_DEPTH, 13, width of the score field.
- IMG_WIDTH, 640, pixels per line.
- IMG_HEIGHT, 480, lines per frame.
- FIFO_DEPTH, 16, keypoint FIFO entries; must be a power of 2, minimum 2.
- MAX_KP, 1024, maximum keypoints accepted per frame.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  score beat valid; delayed by the integrator to align with the NMS output.
- in_sof  in  1  first pixel of a frame; qualified by in_valid.
- in_score  in  PIXEL_SCORE_DEPTH  suppressed score from NMS.
- kp_valid  out  1  FIFO head valid.
- kp_ready  in  1  downstream accepts the head.
- kp_x  out  X_W  head x coordinate.
- kp_y  out  Y_W  head y coordinate.
- kp_score  out  PIXEL_SCORE_DEPTH  head score.
- frame_done  out  1  one-cycle pulse when a frame closes.
- frame_kp_count  out  CNT_W  keypoints written to the FIFO in the closed frame.
- frame_dropped  out  1  closed frame lost at least one keypoint to FIFO-full or the cap.
- frame_short  out  1  closed frame was aborted by an early in_sof.

Behaviour:
- Width rules: X_W = $clog2(IMG_WIDTH), Y_W = $clog2(IMG_HEIGHT), CNT_W = $clog2(MAX_KP+1).
- Reset: synchronous, active-low, clk only.
  - All outputs 0; FIFO emptied; counters cleared; state IDLE.
  - Reset mid-frame discards buffered keypoints and raises no frame_done.
- State machine:
  - IDLE: beats without in_sof are ignored. On in_valid & in_sof, the beat is pixel (0,0) and is processed; go to ACTIVE.
  - ACTIVE: each in_valid beat is processed. x increments; at x = IMG_WIDTH-1, x wraps to 0 and y increments. When kp_cnt reaches MAX_KP, go to CAPPED.
  - CAPPED: coordinate counting continues. Non-zero scores are not written and set the dropped flag.
  - Frame end: a beat at (IMG_WIDTH-1, IMG_HEIGHT-1) closes the frame. frame_done pulses on the following cycle with the stats; go to IDLE.
  - Early sof: in_valid & in_sof while in ACTIVE or CAPPED closes the current frame with frame_short=1, frame_done pulsing next cycle. The same beat starts a new frame as pixel (0,0) in ACTIVE, with counters and flags reset for the new frame.
- Keypoint write:
  - A beat is a keypoint iff in_valid & in_score != 0 and the state, after any sof handling, is ACTIVE.
  - The FIFO entry is {score, y, x} of that beat.
  - FIFO full (registered occupancy == FIFO_DEPTH): the write is dropped, the dropped flag is set, and kp_cnt does not increment. A pop in the same cycle does not make room.
  - kp_cnt increments only on a successful write.
- Output handshake:
  - First-word-fall-through: a write at edge t makes kp_valid=1 after t when the FIFO was empty.
  - Pop on kp_valid & kp_ready.
  - While kp_valid & ~kp_ready, the head fields are stable.
- Stats outputs: frame_kp_count, frame_dropped and frame_short are registered at frame close and hold until the next close or reset.
- The block applies no back-pressure upstream; loss is reported only through frame_dropped.

Decomposition:
- fslam_pkg holds:
  - the kp_entry_t packed struct {score, y, x};
  - the collector state enum {IDLE, ACTIVE, CAPPED};
  - width helper constants.
- Sub-module kp_fifo: synchronous FWFT FIFO.
  - Parameterised on DEPTH and the entry type.
  - Ports: push, push_data, full, pop, head, empty.
  - Same clk/rst_n reset convention.

Test Plan:
- Test config for all scenarios: IMG_WIDTH=8, IMG_HEIGHT=4, FIFO_DEPTH=4, MAX_KP=6.
- Basic: sof, then 32 beats with score 5 at pixel 3 and score 9 at pixel 17, kp_ready=1 -> outputs (3,0,5) then (1,2,9); frame_done 1 cycle after beat 31 with count=2, dropped=0, short=0.
- FIFO full: kp_ready=0, 6 non-zero beats in one frame -> the first 4 buffered, frame_dropped=1, count=4; releasing kp_ready drains 4 entries in order.
- Cap: kp_ready=1, 10 non-zero beats -> exactly 6 emitted, frame_dropped=1, count=6; the next frame accepts keypoints again.
- Early sof: new sof at beat 12 -> frame_done with short=1 and count equal to prior writes. The sof beat is coordinate (0,0), and a non-zero score on it emits (0,0,score).
- Reset mid-frame: rst_n low for 1 cycle while the FIFO holds 3 entries -> kp_valid=0, no frame_done, beats ignored until the next sof.
- Sof qualification: in_sof=1 with in_valid=0, then beats without sof -> all ignored in IDLE; frame_done never pulses.
